// File: rtl/tdm_pkg.sv
// tdm_pkg: shared definitions for the TDM serializer (p2tdm) and deserializer
// (tdm2p).
//   FRAME_BITS : default bits per TDM frame (power of two)
//   SLOT_BITS  : default bits per slot
//   BIT_CNT_W  : width of the in-frame bit counter
//   tdm_state_e: IDLE=0, RUN=1
package tdm_pkg;

  localparam int FRAME_BITS = 256;
  localparam int SLOT_BITS  = 32;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/p2tdm_frame_cnt.sv
// tdmFrameCnt: in-frame bit counter with terminal-count decode.
//   clk, rst : clock, async active-high reset
//   clr      : restart the count at 0 (frame load or stop)
//   inc      : advance by one bit
//   tc       : count has reached FRAME_BITS-1 (last bit of the frame)
module tdmFrameCnt #(
  parameter int FRAME_BITS = tdm_pkg::FRAME_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CNT_W = $clog2(FRAME_BITS);

  logic [CNT_W-1:0] bitCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitCnt <= '0;
    end else if (clr) begin
      bitCnt <= '0;
    end else if (inc) begin
      bitCnt <= bitCnt + 1'b1;
    end
  end

  assign tc = (bitCnt == CNT_W'(FRAME_BITS - 1));

endmodule

// File: rtl/p2tdm.sv
// p2tdm: parallel-to-TDM serializer with a one-frame holding buffer.
// Frames arrive as one-cycle strobes and are shifted out MSB-first, one bit
// per bitEn strobe, with tdmFsync marking the first bit of every frame.
//   clk, rst        : clock, async active-high reset
//   en              : transmit enable, only acted on at frame boundaries
//   bitEn           : one-clk strobe per TDM bit period
//   tdmPdataValidX  : frame strobe for tdmPdataX
//   tdmPdataX       : frame data, MSB sent first
//   tdmSdata        : serial data
//   tdmFsync        : first-bit marker
//   busy            : high while in RUN
//   underrun        : pulse, boundary reached with no frame available
//   overrun         : pulse, buffered frame overwritten before being sent
//   underrunCnt     : saturating underrun count (only with P2TDM_UNDERRUN_CNT_EN)
// Build option: define P2TDM_UNDERRUN_CNT_EN to add the underrunCnt output.
//
// state | meaning
// IDLE  | not transmitting, outputs 0, waiting for en and a frame
// RUN   | shifting a frame out, reloading at every frame boundary
module p2tdm #(
  parameter int FRAME_BITS = tdm_pkg::FRAME_BITS,
  parameter int SLOT_BITS  = tdm_pkg::SLOT_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  bitEn,
  input  logic                  tdmPdataValidX,
  input  logic [FRAME_BITS-1:0] tdmPdataX,
  output logic                  tdmSdata,
  output logic                  tdmFsync,
  output logic                  busy,
  output logic                  underrun,
  output logic                  overrun
`ifdef P2TDM_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrunCnt
`endif
);

  import tdm_pkg::*;

  if (((FRAME_BITS & (FRAME_BITS - 1)) != 0) || ((FRAME_BITS % SLOT_BITS) != 0)) begin : g_bad_cfg
    $error("p2tdm: FRAME_BITS must be a power of two and a multiple of SLOT_BITS");
  end

  tdm_state_e            state;
  logic [FRAME_BITS-1:0] holdReg;
  logic [FRAME_BITS-1:0] shiftReg;
  logic [FRAME_BITS-1:0] srcFrame;
  logic                  holdFull;
  logic                  bitTc;
  logic                  bnd;
  logic                  stop;
  logic                  load;
  logic                  srcHold;
  logic                  srcByp;
  logic                  srcZero;
  logic                  store;
  logic                  ovrEvt;

  always_comb begin
    bnd      = bitEn & (((state == IDLE) & en & (holdFull | tdmPdataValidX)) |
                        ((state == RUN) & bitTc));
    stop     = bnd & (state == RUN) & ~en;
    load     = bnd & ~stop;
    srcHold  = load & holdFull;
    srcByp   = load & ~holdFull & tdmPdataValidX;
    srcZero  = load & ~holdFull & ~tdmPdataValidX;
    srcFrame = holdFull ? holdReg : (tdmPdataValidX ? tdmPdataX : '0);
    // A strobe that did not go straight to the shifter lands in the buffer;
    // it only overruns if the old buffered frame was not just consumed.
    store    = tdmPdataValidX & ~srcByp;
    ovrEvt   = store & holdFull & ~srcHold;
  end

  tdmFrameCnt #(.FRAME_BITS(FRAME_BITS)) u_frame_cnt (
    .clk (clk),
    .rst (rst),
    .clr (load | stop),
    .inc (bitEn & (state == RUN) & ~bnd),
    .tc  (bitTc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      holdReg  <= '0;
      holdFull <= 1'b0;
      shiftReg <= '0;
      tdmSdata <= 1'b0;
      tdmFsync <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      underrun <= srcZero;
      overrun  <= ovrEvt;

      if (stop) begin
        state    <= IDLE;
        tdmSdata <= 1'b0;
        tdmFsync <= 1'b0;
      end else if (load) begin
        state    <= RUN;
        shiftReg <= srcFrame;
        tdmSdata <= srcFrame[FRAME_BITS-1];
        tdmFsync <= 1'b1;
      end else if (bitEn && (state == RUN)) begin
        // shiftReg[MSB] is the bit currently on the line, so the next one is MSB-1
        shiftReg <= shiftReg << 1;
        tdmSdata <= shiftReg[FRAME_BITS-2];
        tdmFsync <= 1'b0;
      end

      if (store) begin
        holdReg  <= tdmPdataX;
        holdFull <= 1'b1;
      end else if (srcHold) begin
        holdFull <= 1'b0;
      end
    end
  end

  assign busy = (state == RUN);

`ifdef P2TDM_UNDERRUN_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrunCnt <= '0;
    end else if (srcZero && (underrunCnt != 16'hFFFF)) begin
      underrunCnt <= underrunCnt + 16'd1;
    end
  end
`endif

endmodule
